// File: rtl/ap_ctrl_latency_profiler_pkg.sv
// Shared types and helpers for the ap_ctrl_hs latency profiler.
// The timestamp-difference helpers operate on 64-bit containers.
package prof_pkg;

    localparam int TS_W_DFLT  = 32;
    localparam int CNT_W_DFLT = 24;
    localparam int FLAGS_W    = 3;

    localparam int FLAG_SAT  = 0;
    localparam int FLAG_DROP = 1;
    localparam int FLAG_INC  = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        STOPPED = 2'd2
    } prof_state_e;

    // Reference record layout at the default widths; the top builds the same
    // layout at its own parameterised widths.
    typedef struct packed {
        logic [TS_W_DFLT-1:0]  start_ts;
        logic [CNT_W_DFLT-1:0] latency;
        logic [CNT_W_DFLT-1:0] interval;
        logic [FLAGS_W-1:0]    flags;
    } prof_rec_t;

    function automatic logic [63:0] wrap_mask(input int unsigned w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] wrap_diff(input logic [63:0] a, input logic [63:0] b,
                                              input int unsigned ts_w);
        return (a - b) & wrap_mask(ts_w);
    endfunction

    function automatic logic diff_saturates(input logic [63:0] a, input logic [63:0] b,
                                            input int unsigned ts_w, input int unsigned cnt_w);
        return wrap_diff(a, b, ts_w) > wrap_mask(cnt_w);
    endfunction

    // a - b modulo 2^ts_w, clamped to 2^cnt_w - 1
    function automatic logic [63:0] sat_sub(input logic [63:0] a, input logic [63:0] b,
                                            input int unsigned ts_w, input int unsigned cnt_w);
        logic [63:0] d;
        d = wrap_diff(a, b, ts_w);
        return (d > wrap_mask(cnt_w)) ? wrap_mask(cnt_w) : d;
    endfunction

endpackage

// File: rtl/ap_ctrl_latency_profiler_fifo.sv
// First-word-fall-through record FIFO; storage is a RAM with a registered read
// plus a bypass register for writes that land directly at an empty head.
module prof_record_fifo
    import prof_pkg::*;
#(
    parameter int W     = $bits(prof_rec_t),
    parameter int DEPTH = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [W-1:0]  ram_rd_q;
    logic [W-1:0]  byp_data_q, byp_data_d;
    logic          byp_sel_q, byp_sel_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          valid_q, valid_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop     = rd_en && valid_q;
        do_push    = wr_en && ((count_q != (AW+1)'(DEPTH)) || do_pop);
        rd_ptr_d   = rd_ptr_q + AW'(do_pop);
        wr_ptr_d   = wr_ptr_q + AW'(do_push);
        count_d    = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        valid_d    = (count_d != '0);
        // A write to the slot that becomes the head cannot be seen through the RAM read yet
        byp_sel_d  = do_push && (wr_ptr_q == rd_ptr_d);
        byp_data_d = byp_sel_d ? wr_data : byp_data_q;
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wr_data;
        end
        ram_rd_q <= mem[rd_ptr_d];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            byp_sel_q  <= 1'b1;
            byp_data_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            byp_sel_q  <= byp_sel_d;
            byp_data_q <= byp_data_d;
        end
    end

    assign rd_data = byp_sel_q ? byp_data_q : ram_rd_q;
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = !valid_q;

endmodule

// File: rtl/ap_ctrl_latency_profiler.sv
// Handshake profiler for one ap_ctrl_hs block: timestamps each transaction and
// queues {start, latency, interval, flags} records for a valid/ready consumer.
module ap_ctrl_latency_profiler
    import prof_pkg::*;
#(
    parameter int TS_W   = 32,
    parameter int CNT_W  = 24,
    parameter int DEPTH  = 8,
    parameter int DROP_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ap_start,
    input  logic              ap_ready,
    input  logic              ap_done,
    input  logic              ap_continue,
    input  logic              finish,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [TS_W-1:0]   rec_start_ts,
    output logic [CNT_W-1:0]  rec_latency,
    output logic [CNT_W-1:0]  rec_interval,
    output logic [2:0]        rec_flags,
    output logic [DROP_W-1:0] drop_count,
    output logic              busy
);

    typedef struct packed {
        logic [TS_W-1:0]    start_ts;
        logic [CNT_W-1:0]   latency;
        logic [CNT_W-1:0]   interval;
        logic [FLAGS_W-1:0] flags;
    } rec_t;

    prof_state_e       state_q, state_d;
    logic [TS_W-1:0]   ts_q, ts_d;
    logic [TS_W-1:0]   start_ts_q, start_ts_d;
    logic [TS_W-1:0]   prev_start_q, prev_start_d;
    logic              first_seen_q, first_seen_d;
    logic [CNT_W-1:0]  interval_q, interval_d;
    logic              int_sat_q, int_sat_d;
    logic              push_q, push_d;
    rec_t              push_rec_q, push_rec_d;
    logic              drop_pending_q, drop_pending_d;
    logic [DROP_W-1:0] drop_count_q, drop_count_d;
    logic              busy_q, busy_d;

    logic [CNT_W-1:0]  lat_now;
    logic              lat_sat;
    logic              done_ok;
    rec_t              wr_rec;
    rec_t              head_rec;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              fifo_accept;

    // ap_ready carries no state information for the profiler
    logic unused_ap_ready;
    assign unused_ap_ready = ap_ready;

    assign pop         = rec_ready && !fifo_empty;
    assign fifo_accept = push_q && (!fifo_full || pop);

    always_comb begin
        ts_d           = ts_q + TS_W'(1);
        state_d        = state_q;
        start_ts_d     = start_ts_q;
        prev_start_d   = prev_start_q;
        first_seen_d   = first_seen_q;
        interval_d     = interval_q;
        int_sat_d      = int_sat_q;
        push_d         = 1'b0;
        push_rec_d     = push_rec_q;
        drop_pending_d = drop_pending_q;
        drop_count_d   = drop_count_q;

        lat_now = CNT_W'(sat_sub(64'(ts_q), 64'(start_ts_q), TS_W, CNT_W));
        lat_sat = diff_saturates(64'(ts_q), 64'(start_ts_q), TS_W, CNT_W);
        done_ok = ap_done && ap_continue;

        unique case (state_q)
            IDLE: begin
                if (finish) begin
                    state_d = STOPPED;
                end else if (ap_start) begin
                    state_d      = RUN;
                    start_ts_d   = ts_q;
                    interval_d   = first_seen_q
                                 ? CNT_W'(sat_sub(64'(ts_q), 64'(prev_start_q), TS_W, CNT_W))
                                 : '0;
                    int_sat_d    = first_seen_q
                                 && diff_saturates(64'(ts_q), 64'(prev_start_q), TS_W, CNT_W);
                    prev_start_d = ts_q;
                    first_seen_d = 1'b1;
                end
            end
            RUN: begin
                if (finish || done_ok) begin
                    push_d                    = 1'b1;
                    push_rec_d.start_ts       = start_ts_q;
                    push_rec_d.latency        = lat_now;
                    push_rec_d.interval       = interval_q;
                    push_rec_d.flags          = '0;
                    push_rec_d.flags[FLAG_SAT] = lat_sat || int_sat_q;
                    push_rec_d.flags[FLAG_INC] = !done_ok;
                    state_d                   = finish ? STOPPED : IDLE;
                end
            end
            STOPPED: begin
                state_d = STOPPED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Drop bookkeeping is resolved when the record reaches the FIFO
        if (push_q) begin
            drop_pending_d = !fifo_accept;
            if (!fifo_accept && (drop_count_q != '1)) begin
                drop_count_d = drop_count_q + DROP_W'(1);
            end
        end

        busy_d = (state_d == RUN);
    end

    always_comb begin
        wr_rec                 = push_rec_q;
        wr_rec.flags[FLAG_DROP] = drop_pending_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            ts_q           <= '0;
            start_ts_q     <= '0;
            prev_start_q   <= '0;
            first_seen_q   <= 1'b0;
            interval_q     <= '0;
            int_sat_q      <= 1'b0;
            push_q         <= 1'b0;
            push_rec_q     <= '0;
            drop_pending_q <= 1'b0;
            drop_count_q   <= '0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            ts_q           <= ts_d;
            start_ts_q     <= start_ts_d;
            prev_start_q   <= prev_start_d;
            first_seen_q   <= first_seen_d;
            interval_q     <= interval_d;
            int_sat_q      <= int_sat_d;
            push_q         <= push_d;
            push_rec_q     <= push_rec_d;
            drop_pending_q <= drop_pending_d;
            drop_count_q   <= drop_count_d;
            busy_q         <= busy_d;
        end
    end

    prof_record_fifo #(
        .W     ($bits(rec_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (push_q),
        .wr_data (wr_rec),
        .rd_en   (pop),
        .rd_data (head_rec),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign rec_valid    = !fifo_empty;
    assign rec_start_ts = head_rec.start_ts;
    assign rec_latency  = head_rec.latency;
    assign rec_interval = head_rec.interval;
    assign rec_flags    = head_rec.flags;
    assign drop_count   = drop_count_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_ap_ctrl_latency_profiler.sv
// Scoreboard bench: expected records are queued as transactions are driven and
// compared as each DUT hands a record over its valid/ready port.
module tb_ap_ctrl_latency_profiler;

    typedef struct {
        longint unsigned st;
        longint unsigned lat;
        longint unsigned itv;
        longint unsigned fl;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;

    // default-width instance
    logic        ap_start = 0, ap_ready = 0, ap_done = 0, ap_continue = 1, finish = 0;
    logic        rec_ready = 1;
    logic        rec_valid;
    logic [31:0] rec_start_ts;
    logic [23:0] rec_latency, rec_interval;
    logic [2:0]  rec_flags;
    logic [15:0] drop_count;
    logic        busy;

    // narrow instance: 8-bit timestamp, 4-bit counters
    logic        s_ap_start = 0, s_ap_ready = 0, s_ap_done = 0, s_ap_continue = 1, s_finish = 0;
    logic        s_rec_ready = 1;
    logic        s_rec_valid;
    logic [7:0]  s_rec_start_ts;
    logic [3:0]  s_rec_latency, s_rec_interval;
    logic [2:0]  s_rec_flags;
    logic [3:0]  s_drop_count;
    logic        s_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int unsigned bts;
    exp_t m_q[$];
    exp_t s_q[$];
    exp_t m_e, s_e;

    always #5 clock = ~clock;

    ap_ctrl_latency_profiler dut (
        .clock(clock), .reset(reset),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
        .ap_continue(ap_continue), .finish(finish),
        .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_start_ts(rec_start_ts), .rec_latency(rec_latency),
        .rec_interval(rec_interval), .rec_flags(rec_flags),
        .drop_count(drop_count), .busy(busy)
    );

    ap_ctrl_latency_profiler #(.TS_W(8), .CNT_W(4), .DEPTH(4), .DROP_W(4)) dut_s (
        .clock(clock), .reset(reset),
        .ap_start(s_ap_start), .ap_ready(s_ap_ready), .ap_done(s_ap_done),
        .ap_continue(s_ap_continue), .finish(s_finish),
        .rec_valid(s_rec_valid), .rec_ready(s_rec_ready),
        .rec_start_ts(s_rec_start_ts), .rec_latency(s_rec_latency),
        .rec_interval(s_rec_interval), .rec_flags(s_rec_flags),
        .drop_count(s_drop_count), .busy(s_busy)
    );

    // Reference timestamp: free-running count of cycles since reset release
    always @(posedge clock or negedge reset) begin
        if (!reset) bts <= 0;
        else        bts <= bts + 1;
    end

    task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic goto_ts(input int unsigned t);
        int guard = 0;
        while (bts != t && guard < 5000) begin
            @(posedge clock);
            #1;
            guard++;
        end
        if (bts != t) chk("ts_reach", bts, t);
    endtask

    task automatic txn(input int unsigned st, input int unsigned dn);
        goto_ts(st);
        ap_start = 1;
        goto_ts(st + 1);
        ap_start = 0;
        goto_ts(dn);
        ap_done = 1;
        goto_ts(dn + 1);
        ap_done = 0;
    endtask

    always @(negedge clock) begin
        if (reset && rec_valid && rec_ready) begin
            $display("main rec start=%0d lat=%0d itv=%0d flags=%b", rec_start_ts, rec_latency,
                     rec_interval, rec_flags);
            if (m_q.size() == 0) begin
                chk("main_unexpected_rec", 1, 0);
            end else begin
                m_e = m_q.pop_front();
                chk("main_start_ts", rec_start_ts, m_e.st);
                chk("main_latency", rec_latency, m_e.lat);
                chk("main_interval", rec_interval, m_e.itv);
                chk("main_flags", rec_flags, m_e.fl);
            end
        end
    end

    always @(negedge clock) begin
        if (reset && s_rec_valid && s_rec_ready) begin
            $display("narrow rec start=%0d lat=%0d itv=%0d flags=%b", s_rec_start_ts,
                     s_rec_latency, s_rec_interval, s_rec_flags);
            if (s_q.size() == 0) begin
                chk("narrow_unexpected_rec", 1, 0);
            end else begin
                s_e = s_q.pop_front();
                chk("narrow_start_ts", s_rec_start_ts, s_e.st);
                chk("narrow_latency", s_rec_latency, s_e.lat);
                chk("narrow_interval", s_rec_interval, s_e.itv);
                chk("narrow_flags", s_rec_flags, s_e.fl);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        chk("rst_rec_valid", rec_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop_count", drop_count, 0);
        chk("rst_rec_start_ts", rec_start_ts, 0);
        chk("rst_rec_latency", rec_latency, 0);
        chk("rst_narrow_valid", s_rec_valid, 0);
        @(negedge clock);
        reset = 1;

        // single transaction, FWFT timing
        goto_ts(10);
        ap_start = 1;
        m_q.push_back('{10, 15, 0, 0});
        goto_ts(11);
        ap_start = 0;
        chk("busy_run", busy, 1);
        goto_ts(25);
        ap_done = 1;
        goto_ts(26);
        ap_done = 0;
        chk("busy_after_done", busy, 0);
        chk("rv_ts26", rec_valid, 0);
        goto_ts(27);
        chk("rv_ts27", rec_valid, 1);

        // back-to-back with ap_start held through completion
        goto_ts(40);
        ap_start = 1;
        m_q.push_back('{40, 10, 30, 0});
        goto_ts(50);
        ap_done = 1;
        m_q.push_back('{51, 9, 11, 0});
        goto_ts(51);
        ap_done = 0;
        goto_ts(52);
        ap_start = 0;
        chk("busy_b2b", busy, 1);
        goto_ts(60);
        ap_done = 1;
        goto_ts(61);
        ap_done = 0;

        // done held while continue is low
        goto_ts(70);
        ap_start = 1;
        m_q.push_back('{70, 25, 19, 0});
        goto_ts(71);
        ap_start = 0;
        goto_ts(85);
        ap_done = 1;
        ap_continue = 0;
        goto_ts(90);
        chk("busy_wait_cont", busy, 1);
        goto_ts(95);
        ap_continue = 1;
        chk("busy_cont_cycle", busy, 1);
        goto_ts(96);
        ap_done = 0;
        chk("busy_after_cont", busy, 0);

        // overflow: 10 transactions into an 8-deep FIFO with no consumer
        goto_ts(99);
        rec_ready = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) m_q.push_back('{100 + 10 * i, 3, (i == 0) ? 30 : 10, 0});
            txn(100 + 10 * i, 103 + 10 * i);
        end
        goto_ts(200);
        chk("drop_count_2", drop_count, 2);
        chk("full_valid", rec_valid, 1);
        chk("hold_head_ts", rec_start_ts, 100);
        rec_ready = 1;
        goto_ts(215);
        chk("drained", rec_valid, 0);
        m_q.push_back('{300, 3, 110, 2});
        txn(300, 303);
        m_q.push_back('{320, 3, 20, 0});
        txn(320, 323);

        // finish mid-run
        goto_ts(400);
        ap_start = 1;
        m_q.push_back('{400, 8, 80, 4});
        goto_ts(401);
        ap_start = 0;
        goto_ts(408);
        finish = 1;
        goto_ts(409);
        finish = 0;
        chk("busy_stopped", busy, 0);
        goto_ts(420);
        ap_start = 1;
        goto_ts(421);
        ap_start = 0;
        chk("busy_ignore_start", busy, 0);
        goto_ts(425);
        ap_done = 1;
        goto_ts(426);
        ap_done = 0;
        goto_ts(440);
        chk("stopped_no_rec", rec_valid, 0);
        chk("main_sb_empty", m_q.size(), 0);

        // narrow instance: saturation and timestamp wrap
        goto_ts(522);
        s_ap_start = 1;
        s_q.push_back('{10, 15, 0, 1});
        goto_ts(523);
        s_ap_start = 0;
        goto_ts(542);
        s_ap_done = 1;
        goto_ts(543);
        s_ap_done = 0;
        goto_ts(765);
        s_ap_start = 1;
        s_q.push_back('{253, 7, 15, 1});
        goto_ts(766);
        s_ap_start = 0;
        goto_ts(772);
        s_ap_done = 1;
        goto_ts(773);
        s_ap_done = 0;
        goto_ts(780);
        chk("narrow_sb_empty", s_q.size(), 0);

        // async reset with a held record and a transaction in flight
        s_rec_ready = 0;
        goto_ts(781);
        s_ap_start = 1;
        goto_ts(782);
        s_ap_start = 0;
        goto_ts(785);
        s_ap_done = 1;
        goto_ts(786);
        s_ap_done = 0;
        goto_ts(790);
        s_ap_start = 1;
        goto_ts(791);
        s_ap_start = 0;
        goto_ts(795);
        chk("pre_rst_valid", s_rec_valid, 1);
        chk("pre_rst_busy", s_busy, 1);
        chk("pre_rst_drop", drop_count, 2);
        #2;
        reset = 0;
        #1;
        chk("async_rst_valid", s_rec_valid, 0);
        chk("async_rst_busy", s_busy, 0);
        chk("async_rst_drop", drop_count, 0);
        chk("async_rst_latency", s_rec_latency, 0);
        @(negedge clock);
        reset = 1;
        s_rec_ready = 1;
        repeat (6) @(posedge clock);
        #1;
        chk("lost_txn_no_rec", s_rec_valid, 0);
        chk("post_rst_busy", s_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ap_ctrl_latency_profiler.md
Name: ap_ctrl_latency_profiler

Overview:
- Synthesizable per-module handshake profiler; taps one HLS block's ap_ctrl_hs signals (ap_start/ap_ready/ap_done/ap_continue) in the hyperspectral design.
- Timestamps every transaction and emits one record per completed transaction: start time, latency, start-to-start interval, flags.
- Records are buffered in a small FIFO and drained over a valid/ready port by the downstream dump/sample stage, which serializes them to the host.
- Gives on-board runs the same per-module status data that cosim module-status monitoring produces.

Parameters:
TS_W, 32, free-running timestamp width (bits)
CNT_W, 24, latency/interval field width; values saturate at 2^CNT_W-1
DEPTH, 8, record FIFO depth; power of two, >=2
DROP_W, 16, dropped-record counter width; saturates

Ports:
clock  in  1  single clock; all logic rising-edge
reset  in  1  asynchronous, active-low reset
ap_start  in  1  tapped ap_start of monitored block
ap_ready  in  1  tapped ap_ready
ap_done  in  1  tapped ap_done
ap_continue  in  1  tapped ap_continue; tie 1 for non-dataflow blocks
finish  in  1  end of run; sampled every cycle
rec_valid  out  1  record available at FIFO head
rec_ready  in  1  consumer accepts head record when rec_valid&rec_ready
rec_start_ts  out  TS_W  timestamp of the transaction's start cycle
rec_latency  out  CNT_W  done cycle minus start cycle
rec_interval  out  CNT_W  this start minus previous start; 0 for first record
rec_flags  out  3  [0] saturated, [1] drop_before, [2] incomplete
drop_count  out  DROP_W  records lost to FIFO full
busy  out  1  high while state==RUN

Behaviour:
- Reset (reset=0, async): state IDLE; ts=0; FIFO empty; rec_valid=0; all rec_* fields=0; drop_count=0; busy=0; first_seen=0; drop_pending=0.
- ts increments by 1 every cycle and wraps modulo 2^TS_W. Differences are computed modulo 2^TS_W, then saturated to CNT_W.
- IDLE: ap_start=1 -> RUN next cycle.
  - Capture start_ts=ts.
  - interval = first_seen ? ts - prev_start : 0.
  - prev_start=ts; first_seen=1.
- RUN: ap_done=1 and ap_continue=1 -> push record, return to IDLE.
  - latency = ts - start_ts.
  - ap_done=1 with ap_continue=0: stay in RUN; latency keeps counting until both are high.
  - ap_ready is informational only and never changes state.
- Back-to-back: ap_start held high through completion -> next transaction starts in the first IDLE cycle. Minimum measured interval = latency + 1.
- saturated flag: set if latency or interval exceeded 2^CNT_W-1; the saturated field reads all ones.
- Push with FIFO full: record discarded; drop_count+=1 (saturating); drop_pending=1. The next successful push carries drop_before=1 and clears drop_pending.
- Simultaneous push and pop with FIFO full: the push succeeds and no drop is recorded.
- finish=1:
  - In RUN: push one record with incomplete=1 and latency = ts - start_ts, then go to STOPPED.
  - In IDLE: go directly to STOPPED.
  - STOPPED ignores all handshake inputs until reset. The FIFO keeps draining.
- FIFO is first-word-fall-through: rec_* fields are registered and valid in the same cycle rec_valid=1. Push-to-rec_valid latency is 1 cycle when the FIFO was empty.
- rec_* fields are stable while rec_valid=1 and rec_ready=0. No combinational path from rec_ready to rec_valid.
- Mid-run reset: the in-flight transaction is lost and no record is emitted.

Decomposition:
- Package prof_pkg holds:
  - typedef prof_state_e {IDLE, RUN, STOPPED};
  - typedef struct prof_rec_t {start_ts, latency, interval, flags};
  - flag bit index constants and the saturating-subtract function.
- One sub-module, prof_record_fifo: parameterized synchronous FWFT FIFO of prof_rec_t, DEPTH entries, with full/empty flags. Same clock and async active-low reset.

Test Plan:
- Reset, then ap_start=1 at ts=10, ap_done&ap_continue at ts=25 -> one record {start_ts=10, latency=15, interval=0, flags=0}; rec_valid rises at ts=27.
- Second start at ts=40, done at ts=50 -> record {40, 10, 30, 0}. ap_start held through done at ts=50 -> next record start_ts=51, interval=11.
- ap_done=1 with ap_continue=0 from ts=20 to 29, continue=1 at ts=30, start at ts=5 -> latency=25; busy=1 throughout.
- rec_ready=0, DEPTH=8, 10 transactions -> 8 records held, drop_count=2. Then drain and run 1 more -> its drop_before=1; the following record has drop_before=0.
- CNT_W=4, latency 20 cycles -> rec_latency=15 with saturated=1. Start at ts=2^TS_W-3, done at ts=4 after wrap -> latency=7.
- finish=1 in RUN at 8 cycles after start -> record with incomplete=1, latency=8; later ap_start pulses produce no records. Async reset mid-RUN -> rec_valid=0 and drop_count=0 immediately.
